iq_magnitude: RTL and testbench



---
 rtl/iq_magnitude_pkg.sv | 75 +++++++
 rtl/iq_magnitude_if.sv | 26 ++
 rtl/iq_magnitude_core.sv | 56 +++++
 rtl/iq_magnitude.sv | 89 ++++++++
 tb/tb_iq_magnitude.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_magnitude_pkg.sv
// Shared sonar types for the I/Q magnitude envelope stage.
// Widths, tuser layout, pipeline bundles and small datapath helpers.
package iq_magnitude_pkg;

    localparam int CH_W     = 2;
    localparam int SAMPLE_W = 24;
    localparam int ABS_W    = SAMPLE_W - 1;
    localparam int NCH      = 1 << CH_W;
    localparam int TUSER_W  = 3;

    localparam int TUSER_CH_LSB = 0;
    localparam int TUSER_CH_MSB = 1;
    localparam int TUSER_IQ     = 2;
    localparam int TUSER_FLAG   = 2;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [SAMPLE_W-1:0]        mag_t;
    typedef logic [ABS_W-1:0]           abs_t;
    typedef logic [CH_W-1:0]            ch_t;

    typedef struct packed {
        logic    vld;
        ch_t     ch;
        sample_t i;
        sample_t q;
    } pair_t;

    typedef struct packed {
        logic vld;
        ch_t  ch;
        abs_t ai;
        abs_t aq;
    } abs_st_t;

    typedef struct packed {
        logic vld;
        ch_t  ch;
        abs_t mx;
        abs_t mn;
    } sort_t;

    typedef struct packed {
        logic vld;
        ch_t  ch;
        logic flag;
        mag_t mag;
    } sum_t;

    // The most negative sample negates onto itself, so clamp it.
    function automatic abs_t abs_sat(input sample_t x);
        sample_t n;
        abs_t    r;
        n = -x;
        if (!x[SAMPLE_W-1])
            r = x[ABS_W-1:0];
        else if (n[SAMPLE_W-1])
            r = '1;
        else
            r = n[ABS_W-1:0];
        return r;
    endfunction

    // Neither partial can go negative and the total stays under 2^24.
    function automatic mag_t alpha_beta(
        input abs_t mx,
        input abs_t mn
    );
        mag_t a;
        mag_t b;
        a = mag_t'(mx) - mag_t'(mx >> 4);
        b = mag_t'(mn >> 1) - mag_t'(mn >> 5);
        return a + b;
    endfunction

endpackage

// File: rtl/iq_magnitude_if.sv
// Stream bundle used on both sides of the magnitude stage.
// Carries tdata/tvalid/tuser forward and tready back.
interface iq_magnitude_if
    import iq_magnitude_pkg::*;
    ;

    logic [SAMPLE_W-1:0] tdata;
    logic                tvalid;
    logic                tready;
    logic [TUSER_W-1:0]  tuser;

    modport master (
        output tdata,
        output tvalid,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/iq_magnitude_core.sv
// Three-stage abs/sort/sum magnitude pipeline, stalled as one by en.
// Threshold flag is built only with IQ_MAG_THRESH_EN defined.
module iq_mag_core
    import iq_magnitude_pkg::*;
#(
    parameter mag_t THRESH = 24'd100000
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  pair_t pair,
    output sum_t  res
);

    abs_st_t p1;
    sort_t   p2;
    sum_t    p3;
    mag_t    sum_mag;
    logic    sum_flag;
    logic    i_big;

    assign i_big   = p1.ai >= p1.aq;
    assign sum_mag = alpha_beta(p2.mx, p2.mn);

`ifdef IQ_MAG_THRESH_EN
    assign sum_flag = sum_mag >= THRESH;
`else
    assign sum_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p1 <= '0;
            p2 <= '0;
            p3 <= '0;
        end else if (en) begin
            p1.vld <= pair.vld;
            p1.ch  <= pair.ch;
            p1.ai  <= abs_sat(pair.i);
            p1.aq  <= abs_sat(pair.q);

            p2.vld <= p1.vld;
            p2.ch  <= p1.ch;
            p2.mx  <= i_big ? p1.ai : p1.aq;
            p2.mn  <= i_big ? p1.aq : p1.ai;

            p3.vld  <= p2.vld;
            p3.ch   <= p2.ch;
            p3.flag <= sum_flag;
            p3.mag  <= sum_mag;
        end
    end

    assign res = p3;

endmodule

// File: rtl/iq_magnitude.sv
// I/Q pairing front end and handshake for the magnitude envelope stage.
// Optional threshold flag in tuser[2]: define IQ_MAG_THRESH_EN.
module iq_magnitude
    import iq_magnitude_pkg::*;
#(
    parameter mag_t THRESH = 24'd100000
) (
    input  logic           s_axis_aclk,
    input  logic           s_axis_arstn,
    iq_magnitude_if.slave  s_axis,
    iq_magnitude_if.master m_axis,
    output logic           pair_err
);

    sample_t          i_buf [NCH];
    logic [NCH-1:0]   i_vld;
    pair_t            pair;
    sum_t             res;

    logic    en;
    logic    acc;
    logic    is_q;
    logic    hit;
    ch_t     ch;
    sample_t din;
    logic    take_i;
    logic    take_q;
    logic    drop_q;

    assign en   = !res.vld || m_axis.tready;
    assign acc  = s_axis.tvalid && s_axis.tready;
    assign ch   = s_axis.tuser[TUSER_CH_MSB:TUSER_CH_LSB];
    assign is_q = s_axis.tuser[TUSER_IQ];
    assign din  = s_axis.tdata;
    assign hit  = i_vld[ch];

    assign s_axis.tready = en && s_axis_arstn;

    always_comb begin
        take_i = 1'b0;
        take_q = 1'b0;
        drop_q = 1'b0;
        unique case (1'b1)
            acc && !is_q:        take_i = 1'b1;
            acc && is_q && hit:  take_q = 1'b1;
            acc && is_q && !hit: drop_q = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_arstn) begin
            i_vld    <= '0;
            pair_err <= 1'b0;
            pair     <= '0;
        end else begin
            if (take_i) begin
                i_buf[ch] <= din;
                i_vld[ch] <= 1'b1;
            end
            if (take_q)
                i_vld[ch] <= 1'b0;
            if ((take_i && hit) || drop_q)
                pair_err <= 1'b1;
            // Issue register: the pair enters abs one edge later.
            if (en) begin
                pair.vld <= take_q;
                pair.ch  <= ch;
                pair.i   <= i_buf[ch];
                pair.q   <= din;
            end
        end
    end

    iq_mag_core #(
        .THRESH (THRESH)
    ) u_core (
        .clk   (s_axis_aclk),
        .rst_n (s_axis_arstn),
        .en    (en),
        .pair  (pair),
        .res   (res)
    );

    assign m_axis.tvalid = res.vld;
    assign m_axis.tdata  = res.mag;
    assign m_axis.tuser  = {res.flag, res.ch};

endmodule

// File: tb/tb_iq_magnitude.sv
// Directed and randomized-backpressure bench for iq_magnitude.
// Expected values come from hand arithmetic and a small integer model.
module tb_iq_magnitude;
    import iq_magnitude_pkg::*;

    localparam int TH = 100000;
    localparam int NPAIRS = 10000;

    typedef struct {
        int mag;
        int tu;
        int cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic pair_err;

    iq_magnitude_if s_if ();
    iq_magnitude_if m_if ();

    iq_magnitude #(
        .THRESH (TH)
    ) dut (
        .s_axis_aclk  (clk),
        .s_axis_arstn (rstn),
        .s_axis       (s_if.slave),
        .m_axis       (m_if.master),
        .pair_err     (pair_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit rnd_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rnd_ready)
            m_if.tready = ($urandom_range(0, 3) != 0);
        else
            m_if.tready = 1'b1;
    end

    obs_t        oq[$];
    int          stall_bad = 0;
    logic        held = 1'b0;
    logic [23:0] hd = '0;
    logic [2:0]  hu = '0;

    always @(negedge clk) begin
        if (held && (m_if.tdata !== hd || m_if.tuser !== hu))
            stall_bad++;
        if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1)
            oq.push_back('{int'({8'd0, m_if.tdata}),
                           int'({29'd0, m_if.tuser}), cyc});
        held = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0)
               && (rstn === 1'b1);
        hd = m_if.tdata;
        hu = m_if.tuser;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] tu, input int d,
                        output int at);
        int k;
        s_if.tdata  = d[23:0];
        s_if.tuser  = tu;
        s_if.tvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (s_if.tready !== 1'b1 && k < 2000) begin
            k++;
            @(negedge clk);
        end
        if (k >= 2000) begin
            n_total++;
            $error("FAIL send_timeout: waited %0d cycles, limit 2000", k);
        end
        @(posedge clk);
        #1;
        at = cyc;
        s_if.tvalid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle(3);
        rstn = 1'b1;
        idle(1);
    endtask

    task automatic pop(output obs_t o);
        if (oq.size() == 0)
            o = '{-1, -1, -1};
        else
            o = oq.pop_front();
    endtask

    function automatic int model(input int i, input int q);
        int ai;
        int aq;
        int mx;
        int mn;
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        if (ai > 8388607) ai = 8388607;
        if (aq > 8388607) aq = 8388607;
        mx = (ai > aq) ? ai : aq;
        mn = (ai > aq) ? aq : ai;
        return mx - mx / 16 + mn / 2 - mn / 32;
    endfunction

    function automatic int etu(input int mag, input int ch);
`ifdef IQ_MAG_THRESH_EN
        return ch + ((mag >= TH) ? 4 : 0);
`else
        return ch + 0 * mag;
`endif
    endfunction

    initial begin
        int   t;
        int   tq;
        int   ich[3];
        int   base;
        int   bad;
        int   k;
        int   em[$];
        int   et[$];
        obs_t o;

        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        rstn = 1'b0;
        idle(3);

        chk("rst_tready", {31'd0, s_if.tready}, 0);
        chk("rst_tvalid", {31'd0, m_if.tvalid}, 0);
        chk("rst_tdata", {8'd0, m_if.tdata}, 0);
        chk("rst_tuser", {29'd0, m_if.tuser}, 0);
        chk("rst_pair_err", {31'd0, pair_err}, 0);
        rstn = 1'b1;
        idle(1);

        // basic pair on ch0
        send(3'd0, 3000, t);
        send(3'd4, 4000, tq);
        idle(6);
        chk("basic_cnt", oq.size(), 1);
        pop(o);
        chk("basic_mag", o.mag, 5157);
        chk("basic_tuser", o.tu, 0);
        chk("basic_latency", o.cyc - tq, 3);

        // saturating abs on ch2
        send(3'd2, -8388608, t);
        send(3'd6, 0, t);
        idle(6);
        chk("sat_cnt", oq.size(), 1);
        pop(o);
        chk("sat_mag", o.mag, 7864320);
        chk("sat_tuser", o.tu, etu(7864320, 2));
        chk("sat_pair_err", {31'd0, pair_err}, 0);

        // interleaved channels
        send(3'd0, -1000, t);
        send(3'd1, -1000, t);
        send(3'd3, -1000, t);
        send(3'd5, 1000, t);
        send(3'd7, 1000, t);
        send(3'd4, 1000, t);
        idle(6);
        chk("ilv_cnt", oq.size(), 3);
        ich = '{1, 3, 0};
        for (int n = 0; n < 3; n++) begin
            pop(o);
            chk($sformatf("ilv_mag%0d", n), o.mag, 1407);
            chk($sformatf("ilv_tuser%0d", n), o.tu, ich[n]);
        end
        chk("ilv_pair_err", {31'd0, pair_err}, 0);

        // lone Q on ch1
        send(3'd5, 1234, t);
        idle(6);
        chk("loneq_cnt", oq.size(), 0);
        chk("loneq_pair_err", {31'd0, pair_err}, 1);

        // double I on ch0
        do_reset();
        chk("reset_clears_err", {31'd0, pair_err}, 0);
        send(3'd0, 10, t);
        send(3'd0, 20, t);
        send(3'd4, 0, t);
        idle(6);
        chk("dbl_cnt", oq.size(), 1);
        pop(o);
        chk("dbl_mag", o.mag, 19);
        chk("dbl_tuser", o.tu, 0);
        chk("dbl_pair_err", {31'd0, pair_err}, 1);

        // reset with two results in flight and ch1 I buffered
        do_reset();
        oq.delete();
        send(3'd2, 500, t);
        send(3'd3, 600, t);
        send(3'd6, 700, t);
        send(3'd7, 800, t);
        send(3'd1, 900, t);
        rstn = 1'b0;
        idle(2);
        rstn = 1'b1;
        idle(8);
        chk("mid_rst_cnt", oq.size(), 0);
        chk("mid_rst_err", {31'd0, pair_err}, 0);
        send(3'd5, 5, t);
        idle(6);
        chk("mid_rst_q_cnt", oq.size(), 0);
        chk("mid_rst_q_err", {31'd0, pair_err}, 1);

        // random pairs under random backpressure
        do_reset();
        oq.delete();
        base = stall_bad;
        rnd_ready = 1'b1;
        for (int p = 0; p < NPAIRS; p++) begin
            logic signed [23:0] ri;
            logic signed [23:0] rq;
            int                 vi;
            int                 vq;
            int                 c;
            c  = $urandom_range(0, 3);
            ri = 24'($urandom());
            rq = 24'($urandom());
            if (p % 16 == 3) ri = 24'h800000;
            if (p % 16 == 9) rq = 24'h800000;
            vi = ri;
            vq = rq;
            send(3'(c), vi, t);
            send(3'(4 + c), vq, t);
            em.push_back(model(vi, vq));
            et.push_back(etu(model(vi, vq), c));
        end
        k = 0;
        while (oq.size() < NPAIRS && k < 5000) begin
            k++;
            idle(1);
        end
        rnd_ready = 1'b0;
        idle(5);
        chk("bp_cnt", oq.size(), NPAIRS);
        bad = 0;
        for (int n = 0; n < NPAIRS; n++) begin
            pop(o);
            if (o.mag != em[n] || o.tu != et[n]) begin
                if (bad < 5)
                    $display("bp entry %0d: got %0d/%0d want %0d/%0d",
                             n, o.mag, o.tu, em[n], et[n]);
                bad++;
            end
        end
        chk("bp_values", bad, 0);
        chk("bp_stall_hold", stall_bad - base, 0);
        chk("bp_pair_err", {31'd0, pair_err}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
